// File: rtl/frequency_jump_detector.sv
// Run-length frequency jump detector: establishes a baseline period from consecutive
// matching samples and reports the first or last departure from it within a frame.
module frequency_jump_detector #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_SAMPLES = 64,
  parameter int TOLERANCE   = 0,
  parameter int MIN_RUN     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          sample_data,
  input  logic                           sample_valid,
  input  logic                           sample_last,
  output logic                           sample_ready,
  input  logic                           mode,
  output logic [$clog2(MAX_SAMPLES)-1:0] frequency_jump_index,
  output logic                           jump_detected,
  output logic [DATA_WIDTH-1:0]          base_period,
  output logic [DATA_WIDTH-1:0]          new_period,
  output logic                           overflow,
  output logic                           scanning_completed
);

  localparam int IDX_W = $clog2(MAX_SAMPLES);
  localparam int CNT_W = $clog2(MAX_SAMPLES + 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(MAX_SAMPLES - 1);
  localparam logic [CNT_W-1:0]      MIN_RUN_C = CNT_W'(MIN_RUN);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_WIDTH:0]   TOL_C     = (DATA_WIDTH + 1)'(TOLERANCE);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BASELINE = 2'd1,
    ST_TRACK    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [DATA_WIDTH-1:0]   ref_r, ref_s;
  logic                    mode_r, mode_s;
  logic                    jump_s, ovf_s;
  logic [IDX_W-1:0]        jidx_s;
  logic [DATA_WIDTH-1:0]   base_s, new_s;
  logic [DATA_WIDTH:0]     samp_ext_s, ref_ext_s, diff_s;
  logic                    match_s, accept_s, last_hit_s, ovf_hit_s;

  // Distance is taken one bit wider so the subtraction never wraps.
  assign samp_ext_s = {1'b0, sample_data};
  assign ref_ext_s  = {1'b0, ref_r};
  assign diff_s     = (samp_ext_s >= ref_ext_s) ? (samp_ext_s - ref_ext_s) : (ref_ext_s - samp_ext_s);
  assign match_s    = (diff_s <= TOL_C);
  assign accept_s   = sample_valid & sample_ready;
  assign last_hit_s = accept_s & sample_last;
  assign ovf_hit_s  = accept_s & ~sample_last & (idx_r == IDX_LAST);

  // Next-state, counters and result values for the current cycle.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    ref_s   = ref_r;
    mode_s  = mode_r;
    jump_s  = jump_detected;
    jidx_s  = frequency_jump_index;
    base_s  = base_period;
    new_s   = new_period;
    ovf_s   = overflow;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          jump_s  = 1'b0;
          jidx_s  = '0;
          base_s  = '0;
          new_s   = '0;
          ovf_s   = 1'b0;
          mode_s  = mode;
          ref_s   = sample_data;
          cnt_s   = CNT_ONE;
          state_s = ST_BASELINE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BASELINE: begin
        if (accept_s && match_s) begin
          cnt_s = cnt_r + 1'b1;
          if ((cnt_r + 1'b1) == MIN_RUN_C) begin
            state_s = ST_TRACK;
            // Once a jump is reported, base_period belongs to that jump.
            base_s  = jump_detected ? base_period : ref_r;
          end else begin
            state_s = ST_BASELINE;
          end
        end else if (accept_s) begin
          ref_s = sample_data;
          cnt_s = CNT_ONE;
        end else begin
          state_s = ST_BASELINE;
        end
      end
      ST_TRACK: begin
        if (accept_s && !match_s && mode_r) begin
          jump_s  = 1'b1;
          jidx_s  = idx_r;
          new_s   = sample_data;
          base_s  = ref_r;
          ref_s   = sample_data;
          cnt_s   = CNT_ONE;
          state_s = ST_BASELINE;
        end else if (accept_s && !match_s && !jump_detected) begin
          jump_s = 1'b1;
          jidx_s = idx_r;
          new_s  = sample_data;
        end else begin
          state_s = ST_TRACK;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        idx_s   = '0;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = '0;
      end
    endcase
    idx_s   = accept_s ? (idx_r + 1'b1) : idx_s;
    ovf_s   = ovf_hit_s ? 1'b1 : ovf_s;
    state_s = (last_hit_s || ovf_hit_s) ? ST_DONE : state_s;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r              <= ST_IDLE;
      idx_r                <= '0;
      cnt_r                <= '0;
      ref_r                <= '0;
      mode_r               <= 1'b0;
      jump_detected        <= 1'b0;
      frequency_jump_index <= '0;
      base_period          <= '0;
      new_period           <= '0;
      overflow             <= 1'b0;
      scanning_completed   <= 1'b0;
      sample_ready         <= 1'b1;
    end else begin
      state_r              <= state_s;
      idx_r                <= idx_s;
      cnt_r                <= cnt_s;
      ref_r                <= ref_s;
      mode_r               <= mode_s;
      jump_detected        <= jump_s;
      frequency_jump_index <= jidx_s;
      base_period          <= base_s;
      new_period           <= new_s;
      overflow             <= ovf_s;
      scanning_completed   <= (state_s == ST_DONE);
      sample_ready         <= (state_s != ST_DONE);
    end
  end

endmodule

// File: tb/tb_frequency_jump_detector.sv
// Directed bench: instance a (MAX_SAMPLES=8, exact match) and instance b (TOLERANCE=1).
module tb_frequency_jump_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_data;
  logic       sample_last;
  logic       mode;
  logic       valid_a, valid_b;

  logic       ready_a, jump_a, ovf_a, done_a;
  logic [2:0] jidx_a;
  logic [7:0] base_a, new_a;
  logic       ready_b, jump_b, ovf_b, done_b;
  logic [5:0] jidx_b;
  logic [7:0] base_b, new_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  frequency_jump_detector #(.DATA_WIDTH(8), .MAX_SAMPLES(8), .TOLERANCE(0), .MIN_RUN(2)) dut_a (
    .clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(valid_a),
    .sample_last(sample_last), .sample_ready(ready_a), .mode(mode),
    .frequency_jump_index(jidx_a), .jump_detected(jump_a), .base_period(base_a),
    .new_period(new_a), .overflow(ovf_a), .scanning_completed(done_a)
  );

  frequency_jump_detector #(.DATA_WIDTH(8), .MAX_SAMPLES(64), .TOLERANCE(1), .MIN_RUN(2)) dut_b (
    .clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(valid_b),
    .sample_last(sample_last), .sample_ready(ready_b), .mode(mode),
    .frequency_jump_index(jidx_b), .jump_detected(jump_b), .base_period(base_b),
    .new_period(new_b), .overflow(ovf_b), .scanning_completed(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic res_a(input string tag, input logic j, input logic [31:0] ix,
                       input logic [31:0] b, input logic [31:0] np, input logic ov);
    chk({tag, ".jump"}, jump_a, j);
    chk({tag, ".index"}, jidx_a, ix);
    chk({tag, ".base"}, base_a, b);
    chk({tag, ".new"}, new_a, np);
    chk({tag, ".overflow"}, ovf_a, ov);
  endtask

  task automatic res_b(input string tag, input logic j, input logic [31:0] ix,
                       input logic [31:0] b, input logic [31:0] np);
    chk({tag, ".jump"}, jump_b, j);
    chk({tag, ".index"}, jidx_b, ix);
    chk({tag, ".base"}, base_b, b);
    chk({tag, ".new"}, new_b, np);
    chk({tag, ".overflow"}, ovf_b, 1'b0);
  endtask

  // Presents one sample and returns #1 after the edge that transfers it.
  task automatic send(input bit on_b, input logic [7:0] d, input logic l);
    int n;
    @(negedge clk);
    sample_data = d;
    sample_last = l;
    n = 0;
    while (((on_b ? ready_b : ready_a) !== 1'b1) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", on_b ? ready_b : ready_a, 1'b1);
    if (on_b) valid_b = 1'b1;
    else valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    valid_a     = 1'b0;
    valid_b     = 1'b0;
    sample_data = 8'd0;
    sample_last = 1'b0;
    mode        = 1'b0;
    #12;
    res_a("reset", 1'b0, 0, 0, 0, 1'b0);
    chk("reset.done", done_a, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_reset.ready", ready_a, 1'b1);

    // first-jump mode: 3,3,3,1,1
    mode = 1'b0;
    send(0, 8'd3, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd1, 1'b0);
    chk("f1.no_done_yet", done_a, 1'b0);
    send(0, 8'd1, 1'b1);
    chk("f1.done", done_a, 1'b1);
    chk("f1.ready_low", ready_a, 1'b0);
    res_a("f1", 1'b1, 3, 3, 1, 1'b0);
    @(posedge clk); #1;
    chk("f1.done_pulse_end", done_a, 1'b0);
    chk("f1.ready_back", ready_a, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    res_a("f1.hold", 1'b1, 3, 3, 1, 1'b0);

    // baseline restart: 2,4,4,4,7
    send(0, 8'd2, 1'b0); send(0, 8'd4, 1'b0); send(0, 8'd4, 1'b0); send(0, 8'd4, 1'b0);
    send(0, 8'd7, 1'b1);
    chk("f2.done", done_a, 1'b1);
    res_a("f2", 1'b1, 4, 4, 7, 1'b0);

    // last-jump mode with idle gaps; mode only sampled on the first sample
    mode = 1'b1;
    send(0, 8'd3, 1'b0);
    mode = 1'b0;
    repeat (3) @(negedge clk);
    send(0, 8'd3, 1'b0); send(0, 8'd1, 1'b0);
    repeat (2) @(negedge clk);
    send(0, 8'd1, 1'b0); send(0, 8'd5, 1'b0); send(0, 8'd5, 1'b1);
    chk("f3.done", done_a, 1'b1);
    res_a("f3", 1'b1, 4, 1, 5, 1'b0);

    // steady frame
    send(0, 8'd2, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd2, 1'b0); send(0, 8'd2, 1'b1);
    res_a("f4", 1'b0, 0, 2, 0, 1'b0);

    // frames ending before a baseline exists
    send(0, 8'd9, 1'b1);
    chk("f5.done", done_a, 1'b1);
    res_a("f5", 1'b0, 0, 0, 0, 1'b0);
    send(0, 8'd9, 1'b0); send(0, 8'd8, 1'b1);
    res_a("f6", 1'b0, 0, 0, 0, 1'b0);

    // tolerance 1: 5,6,5,4 no jump; 5,5,7 jumps at index 2
    send(1, 8'd5, 1'b0); send(1, 8'd6, 1'b0); send(1, 8'd5, 1'b0); send(1, 8'd4, 1'b1);
    chk("t1.done", done_b, 1'b1);
    res_b("t1", 1'b0, 0, 5, 0);
    send(1, 8'd5, 1'b0); send(1, 8'd5, 1'b0); send(1, 8'd7, 1'b1);
    res_b("t2", 1'b1, 2, 5, 7);

    // overflow: 8 samples without last, then 2 more form a new frame
    for (int i = 0; i < 8; i++) send(0, 8'd6, 1'b0);
    chk("ovf.done", done_a, 1'b1);
    chk("ovf.ready_low", ready_a, 1'b0);
    res_a("ovf", 1'b0, 0, 6, 0, 1'b1);
    @(posedge clk); #1;
    chk("ovf.ready_back", ready_a, 1'b1);
    chk("ovf.done_end", done_a, 1'b0);
    chk("ovf.hold", ovf_a, 1'b1);
    send(0, 8'd6, 1'b0); send(0, 8'd6, 1'b1);
    chk("ovf2.done", done_a, 1'b1);
    res_a("ovf2", 1'b0, 0, 6, 0, 1'b0);

    // asynchronous reset mid-frame after a jump at index 3
    send(0, 8'd3, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd1, 1'b0);
    chk("mid.jump_seen", jump_a, 1'b1);
    chk("mid.index_seen", jidx_a, 3);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    res_a("mid_reset", 1'b0, 0, 0, 0, 1'b0);
    chk("mid_reset.done", done_a, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    send(0, 8'd3, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd3, 1'b0); send(0, 8'd1, 1'b0);
    send(0, 8'd1, 1'b1);
    chk("after_reset.done", done_a, 1'b1);
    res_a("after_reset", 1'b1, 3, 3, 1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
